// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    ACC1,
    ACC2,
    RESP,
    ERR
  } lsu_state_e;

  // Byte-lane mask of an access before it is shifted to its offset.
  // The unused size code is treated as a word.
  function automatic logic [3:0] size_mask(input lsu_size_e size);
    case (size)
      BYTE:    size_mask = 4'b0001;
      HALF:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // An access splits when its bytes straddle a word boundary.
  function automatic logic needs_split(input lsu_size_e size, input logic [1:0] offset);
    case (size)
      BYTE:    needs_split = 1'b0;
      HALF:    needs_split = (offset == 2'd3);
      default: needs_split = (offset != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte enables and shifted store data for one word of an
// access, and merge plus sign/zero extension of returned load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_offset,
  input  logic        i_st_part,     // 0 = first (or only) word, 1 = second word
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_offset,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_lo,
  input  logic [31:0] i_ld_hi,
  output logic [31:0] o_ld_rdata
);

  logic [7:0]  w_be8;
  logic [63:0] w_wdata64;
  logic [31:0] w_merged;
  logic        w_sext;

  // The 8-bit enable and 64-bit data span both words; the part picks a half.
  assign w_be8      = {4'b0000, size_mask(lsu_size_e'(i_st_size))} << i_st_offset;
  assign o_st_be    = i_st_part ? w_be8[7:4] : w_be8[3:0];
  assign w_wdata64  = {32'h0, i_st_wdata} << {i_st_offset, 3'b000};
  assign o_st_wdata = i_st_part ? w_wdata64[63:32] : w_wdata64[31:0];

  // For an aligned load both words carry the same data, so hi never matters.
  assign w_merged = 32'({i_ld_hi, i_ld_lo} >> {i_ld_offset, 3'b000});
  assign w_sext   = ~i_ld_unsigned;

  // Select the loaded field and extend it to 32 bits.
  always_comb begin
    o_ld_rdata = w_merged;
    case (lsu_size_e'(i_ld_size))
      BYTE:    o_ld_rdata = {{24{w_sext & w_merged[7]}}, w_merged[7:0]};
      HALF:    o_ld_rdata = {{16{w_sext & w_merged[15]}}, w_merged[15:0]};
      default: o_ld_rdata = w_merged;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, issues one or two word
// transactions to data memory and returns a single response.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_we,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [31:0]           lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_resp_valid,
  output logic                  lsu_resp_err,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  data_req,
  output logic                  data_we,
  output logic [3:0]            data_be,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  data_rvalid,
  input  logic [DATA_WIDTH-1:0] data_rdata
);

  localparam logic [ADDR_WIDTH-1:0] WORD_ONE = 1;

  lsu_state_e            r_state, w_state_next;
  logic                  r_we, r_unsigned, r_split;
  logic [1:0]            r_size, r_off;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [31:0]           r_wdata, r_lo;
  logic                  r_data_req, r_data_we;
  logic [3:0]            r_data_be;
  logic [ADDR_WIDTH-1:0] r_data_addr;
  logic [31:0]           r_data_wdata;

  logic                  w_idle, w_accept, w_in_split, w_in_err, w_sel_we;
  logic [1:0]            w_in_off;
  logic [ADDR_WIDTH-1:0] w_in_word;
  logic [3:0]            w_st_be;
  logic [31:0]           w_st_wdata, w_ld_rdata;
  logic                  w_req_next, w_we_next;
  logic [3:0]            w_be_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [31:0]           w_wdata_next;

  assign w_idle     = (r_state == IDLE);
  assign w_accept   = w_idle && lsu_valid;
  assign w_in_off   = lsu_addr[1:0];
  assign w_in_word  = lsu_addr[ADDR_WIDTH+1:2];
  assign w_in_split = needs_split(lsu_size_e'(lsu_size), w_in_off);
  // Split accesses may not wrap from the last word back to word 0.
  assign w_in_err   = (|lsu_addr[31:ADDR_WIDTH+2]) || (w_in_split && (&w_in_word));
  assign w_sel_we   = w_idle ? lsu_we : r_we;

  // Store path sees the incoming request in IDLE and the held one in ACC1.
  lsu_align u_align (
    .i_st_size     (w_idle ? lsu_size  : r_size),
    .i_st_offset   (w_idle ? w_in_off  : r_off),
    .i_st_part     (r_state == ACC1),
    .i_st_wdata    (w_idle ? lsu_wdata : r_wdata),
    .o_st_be       (w_st_be),
    .o_st_wdata    (w_st_wdata),
    .i_ld_size     (r_size),
    .i_ld_offset   (r_off),
    .i_ld_unsigned (r_unsigned),
    .i_ld_lo       (r_split ? r_lo : data_rdata),
    .i_ld_hi       (data_rdata),
    .o_ld_rdata    (w_ld_rdata)
  );

  // Next state and the memory-port values for the coming cycle.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = 1'b0;
    w_we_next    = 1'b0;
    w_be_next    = 4'b0000;
    w_addr_next  = '0;
    w_wdata_next = 32'h0;
    case (r_state)
      IDLE: begin
        if (lsu_valid) begin
          if (w_in_err) begin
            w_state_next = ERR;
          end else begin
            w_state_next = w_in_split ? ACC1 : ACC;
            w_req_next   = 1'b1;
            w_we_next    = lsu_we;
            w_be_next    = w_st_be;
            w_addr_next  = w_in_word;
            w_wdata_next = w_sel_we ? w_st_wdata : 32'h0;
          end
        end
      end
      ACC1: begin
        w_state_next = ACC2;
        w_req_next   = 1'b1;
        w_we_next    = r_we;
        w_be_next    = w_st_be;
        w_addr_next  = r_word + WORD_ONE;
        w_wdata_next = w_sel_we ? w_st_wdata : 32'h0;
      end
      ACC, ACC2: w_state_next = RESP;
      RESP, ERR: w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // State, request capture, first-word capture and registered memory port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_split      <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_word       <= '0;
      r_wdata      <= 32'h0;
      r_lo         <= 32'h0;
      r_data_req   <= 1'b0;
      r_data_we    <= 1'b0;
      r_data_be    <= 4'b0000;
      r_data_addr  <= '0;
      r_data_wdata <= 32'h0;
    end else begin
      r_state      <= w_state_next;
      r_data_req   <= w_req_next;
      r_data_we    <= w_we_next;
      r_data_be    <= w_be_next;
      r_data_addr  <= w_addr_next;
      r_data_wdata <= w_wdata_next;
      if (w_accept) begin
        r_we       <= lsu_we;
        r_unsigned <= lsu_unsigned;
        r_split    <= w_in_split;
        r_size     <= lsu_size;
        r_off      <= w_in_off;
        r_word     <= w_in_word;
        r_wdata    <= lsu_wdata;
      end
      if (r_state == ACC2 && !r_we) begin
        r_lo <= data_rdata;
      end
    end
  end

  assign lsu_ready      = w_idle;
  assign lsu_resp_valid = (r_state == RESP) || (r_state == ERR);
  assign lsu_resp_err   = (r_state == ERR);
  assign lsu_rdata      = (r_state == RESP && !r_we) ? w_ld_rdata : '0;
  assign data_req       = r_data_req;
  assign data_we        = r_data_we;
  assign data_be        = r_data_be;
  assign data_addr      = r_data_addr;
  assign data_wdata     = r_data_wdata;

  // A load must see read data in every cycle that consumes it.
  a_rvalid_present: assert property (@(posedge clk) disable iff (!rst_n)
    ((r_state == ACC2 || r_state == RESP) && !r_we) |-> data_rvalid);

endmodule
